oam_dma_engine: RTL and testbench
=================================

// Module: oam_dma_engine
// PURPOSE
// Bus initiator that copies a 160-byte page from system memory into sprite OAM,
// the write-side counterpart of the graphics peripheral's OAM responder. The CPU
// writes a source high byte to DMA_ADDR; the engine requests the data bus and
// runs read/write pairs (src page -> OAM_BASE) until XFER_LEN bytes are copied.
// PARAMETERS
// ADDR_W    16       bus address width
// DATA_W    8        bus data width
// DMA_ADDR  16'hFF46 CPU-visible start/source register address
// OAM_BASE  16'hFE00 destination base address
// XFER_LEN  160      bytes per transfer (1..256)
// PORTS
// clk      in   1       system clock, all logic posedge
// reset    in   1       synchronous, active-high
// s_addr   in   ADDR_W  responder-side address from CPU
// s_wdata  in   DATA_W  responder-side write data
// s_we     in   1       CPU write strobe
// s_re     in   1       CPU read strobe
// s_rdata  out  DATA_W  read data, valid cycle after s_re hit
// s_rd_en  out  1       high when s_rdata must drive the bus
// m_req    out  1       bus request to arbiter
// m_gnt    in   1       bus grant
// m_addr   out  ADDR_W  initiator address
// m_wdata  out  DATA_W  initiator write data
// m_rd     out  1       initiator read strobe
// m_wr     out  1       initiator write strobe
// m_rdata  in   DATA_W  read data, valid exactly 1 cycle after m_rd
// busy     out  1       transfer in progress (CPU/video arbiter use)
// done     out  1       1-cycle pulse after final OAM write
// BEHAVIOUR
// - Reset: all outputs 0; src register 0; state IDLE; index 0. Reset mid-
//   transfer aborts immediately; no further m_rd/m_wr; no done pulse.
// - s_we with s_addr==DMA_ADDR: src<=s_wdata, index<=0, state<=REQ, next cycle.
//   Applies in any state (mid-transfer write restarts with new source).
// - s_re with s_addr==DMA_ADDR: next cycle s_rd_en=1, s_rdata=src; else s_rd_en=0.
// - FSM IDLE->REQ->READ->WAIT->WRITE->(READ | DONE)->IDLE.
//   REQ: m_req=1; advance to READ on cycle m_gnt sampled 1.
//   READ: m_rd=1, m_addr={src,8'h00}+index (ADDR_W wrap, no carry out).
//   WAIT: latch m_rdata into data reg at end of cycle.
//   WRITE: m_wr=1, m_addr=OAM_BASE+index, m_wdata=data reg; index++.
//     index==XFER_LEN-1 at WRITE -> DONE, else READ.
//   DONE: done=1 for this cycle, m_req=0 -> IDLE.
// - m_req held 1 from REQ through WRITE of last byte; busy=1 in REQ..DONE.
// - m_rd/m_wr only asserted while m_gnt=1; if m_gnt drops in READ/WRITE,
//   hold state and index, strobes 0, resume when m_gnt returns. Drop in WAIT:
//   data still latched (memory already launched).
// - Per byte 3 granted cycles; full 160-byte run = 1 REQ + 480 + 1 DONE cycles.
// - m_rd and m_wr never high in same cycle; m_addr/m_wdata 0 when strobes idle.
// - Simultaneous reset and s_we: reset wins. s_we to DMA_ADDR in DONE cycle:
//   done still pulses, new transfer starts next cycle.
// CONFIGURATION
// OAM_DMA_STATUS_EN defined: status reg at DMA_ADDR+1, read-only;
//   bit0=busy, bit7=sticky done (set on DONE, cleared by status read or
//   reset), other bits 0; read timing as DMA_ADDR.
// Undefined: DMA_ADDR+1 not decoded (s_rd_en stays 0); done pulse only.
// TESTING
// 1. Write 8'hC1 to FF46, gnt tied 1 -> m_rd at C100..C19F, m_wr FE00..FE9F,
//    data matches model memory, done pulses once after 482 cycles, busy low.
// 2. Read FF46 after write 8'h80 -> s_rd_en=1, s_rdata=8'h80 next cycle.
// 3. Deassert m_gnt 10 cycles at byte 50 READ -> no strobes for 10 cycles,
//    transfer resumes at C132, final OAM image correct, done once.
// 4. Rewrite FF46=8'hD0 at byte 100 -> index restarts, OAM FE00..FE9F = D000..
//    D09F, only one done pulse.
// 5. Assert reset at byte 30 -> next cycle m_req/m_rd/m_wr/busy=0, no done,
//    FF46 reads 0.
// 6. (OAM_DMA_STATUS_EN) read FF47 mid-run -> 8'h01; after done -> 8'h80;
//    second read -> 8'h00.

Source files
------------

// File: rtl/oam_dma_engine.sv
// OAM DMA engine: copies XFER_LEN bytes from page {src,8'h00} to OAM_BASE over a granted bus.
// Optional status register at DMA_ADDR+1 is enabled by defining OAM_DMA_STATUS_EN.
module oam_dma_engine #(
  parameter int                  ADDR_W   = 16,
  parameter int                  DATA_W   = 8,
  parameter logic [ADDR_W-1:0]   DMA_ADDR = 16'hFF46,
  parameter logic [ADDR_W-1:0]   OAM_BASE = 16'hFE00,
  parameter int                  XFER_LEN = 160
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic [DATA_W-1:0] s_wdata,
  input  logic              s_we,
  input  logic              s_re,
  output logic [DATA_W-1:0] s_rdata,
  output logic              s_rd_en,
  output logic              m_req,
  input  logic              m_gnt,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic              m_rd,
  output logic              m_wr,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              busy,
  output logic              done,
  output logic [2:0]        o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_READ  = 3'd2,
    S_WAIT  = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

  state_t            r_state;
  state_t            w_next_state;
  logic [DATA_W-1:0] r_src;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] r_rdata;
  logic [7:0]        r_index;
  logic              r_rd_en;
  logic              w_cfg_wr;
  logic              w_cfg_rd;
  logic [ADDR_W-1:0] w_rd_addr;

  assign w_cfg_wr    = s_we && (s_addr == DMA_ADDR);
  assign w_cfg_rd    = s_re && (s_addr == DMA_ADDR);
  assign w_rd_addr   = ADDR_W'({r_src, 8'h00}) + ADDR_W'(r_index);
  assign s_rdata     = r_rdata;
  assign s_rd_en     = r_rd_en;
  assign o_dbg_state = r_state;

`ifdef OAM_DMA_STATUS_EN
  logic              r_done_sticky;
  logic              w_stat_rd;
  logic [DATA_W-1:0] w_status;

  assign w_stat_rd = s_re && (s_addr == ADDR_W'(DMA_ADDR + 1'b1));
  always_comb begin
    w_status    = '0;
    w_status[0] = busy;
    w_status[7] = r_done_sticky;
  end
`endif

  // Strobes are gated by the live grant; losing it parks READ/WRITE in place.
  always_comb begin
    w_next_state = r_state;
    m_req        = 1'b0;
    m_rd         = 1'b0;
    m_wr         = 1'b0;
    m_addr       = '0;
    m_wdata      = '0;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE: ;
      S_REQ: begin
        m_req = 1'b1;
        busy  = 1'b1;
        if (m_gnt) w_next_state = S_READ;
      end
      S_READ: begin
        m_req = 1'b1;
        busy  = 1'b1;
        if (m_gnt) begin
          m_rd         = 1'b1;
          m_addr       = w_rd_addr;
          w_next_state = S_WAIT;
        end
      end
      S_WAIT: begin
        m_req        = 1'b1;
        busy         = 1'b1;
        w_next_state = S_WRITE;
      end
      S_WRITE: begin
        m_req = 1'b1;
        busy  = 1'b1;
        if (m_gnt) begin
          m_wr         = 1'b1;
          m_addr       = OAM_BASE + ADDR_W'(r_index);
          m_wdata      = r_data;
          w_next_state = (r_index == LAST_IDX) ? S_DONE : S_READ;
        end
      end
      S_DONE: begin
        busy         = 1'b1;
        done         = 1'b1;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
    if (w_cfg_wr) w_next_state = S_REQ;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_src   <= '0;
      r_data  <= '0;
      r_index <= '0;
      r_rd_en <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next_state;
      // Memory was already launched in READ, so WAIT latches regardless of grant.
      if (r_state == S_WAIT) r_data <= m_rdata;
      if (w_cfg_wr) begin
        r_src   <= s_wdata;
        r_index <= '0;
      end else if ((r_state == S_WRITE) && m_gnt) begin
        r_index <= r_index + 8'd1;
      end
      if (w_cfg_rd) begin
        r_rd_en <= 1'b1;
        r_rdata <= r_src;
`ifdef OAM_DMA_STATUS_EN
      end else if (w_stat_rd) begin
        r_rd_en <= 1'b1;
        r_rdata <= w_status;
`endif
      end else begin
        r_rd_en <= 1'b0;
        r_rdata <= '0;
      end
    end
  end

`ifdef OAM_DMA_STATUS_EN
  // A completion landing on the same cycle as a status read is kept, not lost.
  always_ff @(posedge clk) begin
    if (reset)                  r_done_sticky <= 1'b0;
    else if (r_state == S_DONE) r_done_sticky <= 1'b1;
    else if (w_stat_rd)         r_done_sticky <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_oam_dma_engine.sv
// Self-checking bench for oam_dma_engine: memory model, read/write scoreboards,
// grant drop, restart, reset abort, DONE-cycle restart and status register.
module tb_oam_dma_engine;

  localparam logic [15:0] DMA_ADDR = 16'hFF46;
  localparam logic [15:0] OAM_BASE = 16'hFE00;
  localparam int          XFER_LEN = 160;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] s_addr;
  logic [7:0]  s_wdata;
  logic        s_we;
  logic        s_re;
  logic [7:0]  s_rdata;
  logic        s_rd_en;
  logic        m_req;
  logic        m_gnt;
  logic [15:0] m_addr;
  logic [7:0]  m_wdata;
  logic        m_rd;
  logic        m_wr;
  logic [7:0]  m_rdata;
  logic        busy;
  logic        done;
  logic [2:0]  dbg_state;

  logic [7:0]  mem [65536];
  logic [15:0] rd_q [$];
  logic [23:0] wr_q [$];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int strobe_cnt = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int wr_cyc = 0;
  logic        rd_pend = 1'b0;
  logic [15:0] rd_addr = '0;

  oam_dma_engine #(
    .ADDR_W(16), .DATA_W(8), .DMA_ADDR(DMA_ADDR), .OAM_BASE(OAM_BASE), .XFER_LEN(XFER_LEN)
  ) dut (
    .clk(clk), .reset(reset), .s_addr(s_addr), .s_wdata(s_wdata), .s_we(s_we), .s_re(s_re),
    .s_rdata(s_rdata), .s_rd_en(s_rd_en), .m_req(m_req), .m_gnt(m_gnt), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rd(m_rd), .m_wr(m_wr), .m_rdata(m_rdata), .busy(busy), .done(done),
    .o_dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // memory responder: data valid exactly one cycle after m_rd, noise otherwise
  always @(posedge clk) begin
    #1;
    m_rdata = rd_pend ? mem[rd_addr] : 8'($urandom_range(0, 255));
  end

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [15:0] er;
    logic [23:0] ew;
    if (!reset) begin
      if (m_rd || m_wr) begin
        strobe_cnt++;
        check("strobe_gnt", m_gnt, 1);
        check("rd_wr_excl", m_rd & m_wr, 0);
      end else begin
        check("idle_bus", {m_addr, m_wdata}, 0);
      end
      if (m_rd) begin
        check("rd_pending", rd_q.size() != 0, 1);
        if (rd_q.size() != 0) begin
          er = rd_q.pop_front();
          check("rd_addr", m_addr, er);
        end
      end
      if (m_wr) begin
        wr_cnt++;
        check("wr_pending", wr_q.size() != 0, 1);
        if (wr_q.size() != 0) begin
          ew = wr_q.pop_front();
          check("wr_addr", m_addr, ew[23:8]);
          check("wr_data", m_wdata, ew[7:0]);
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
    rd_pend = m_rd & ~reset;
    rd_addr = m_addr;
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    s_addr = a; s_wdata = d; s_we = 1'b1; wr_cyc = cyc;
    tick();
    s_we = 1'b0; s_addr = '0; s_wdata = '0;
  endtask

  task automatic cpu_read(input logic [15:0] a, input logic exp_en, input logic [7:0] exp_d,
                          input string tag);
    s_addr = a; s_re = 1'b1;
    tick();
    s_re = 1'b0; s_addr = '0;
    check({tag, "_en"}, s_rd_en, exp_en);
    if (exp_en) check({tag, "_data"}, s_rdata, exp_d);
  endtask

  task automatic start_xfer(input logic [7:0] src);
    logic [15:0] a;
    cpu_write(DMA_ADDR, src);
    rd_q.delete();
    wr_q.delete();
    for (int i = 0; i < XFER_LEN; i++) begin
      a = {src, 8'h00} + 16'(i);
      rd_q.push_back(a);
      wr_q.push_back({OAM_BASE + 16'(i), mem[a]});
    end
  endtask

  task automatic wait_done(input int base, input string tag);
    for (int k = 0; k < 3000 && done_cnt == base; k++) tick();
    check({tag, "_done_seen"}, done_cnt != base, 1);
  endtask

  task automatic wait_wr(input int target, input string tag);
    for (int k = 0; k < 3000 && wr_cnt < target; k++) tick();
    check({tag, "_wr_reached"}, wr_cnt >= target, 1);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_req"}, m_req, 0);
    check({tag, "_rd_q_empty"}, rd_q.size(), 0);
    check({tag, "_wr_q_empty"}, wr_q.size(), 0);
  endtask

  initial begin
    int base_d;
    int base_w;
    int s0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom_range(0, 255));
    reset = 1'b1; m_gnt = 1'b1; s_addr = '0; s_wdata = '0; s_we = 1'b0; s_re = 1'b0;
    repeat (3) tick();
    reset = 1'b0;

    // reset state
    check("rst_req", m_req, 0);
    check("rst_strobes", {m_rd, m_wr}, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_en", s_rd_en, 0);
    check("rst_state", dbg_state, 0);
    cpu_read(DMA_ADDR, 1'b1, 8'h00, "rst_src");

    // full run from page C1 with grant tied high
    base_d = done_cnt;
    start_xfer(8'hC1);
    wait_done(base_d, "t1");
    check("t1_latency", done_cyc - wr_cyc, 482);
    tick();
    check("t1_done_once", done_cnt - base_d, 1);
    check_quiet("t1");
`ifndef OAM_DMA_STATUS_EN
    cpu_read(DMA_ADDR + 16'd1, 1'b0, 8'h00, "stat_undecoded");
`endif

    // source readback right after the write
    base_d = done_cnt;
    start_xfer(8'h80);
    cpu_read(DMA_ADDR, 1'b1, 8'h80, "t2_src");
    wait_done(base_d, "t2");
    tick();
    check_quiet("t2");

    // grant withdrawn for 10 cycles at the READ of byte 50
    base_d = done_cnt;
    base_w = wr_cnt;
    start_xfer(8'hC1);
    wait_wr(base_w + 50, "t3");
    m_gnt = 1'b0;
    s0 = strobe_cnt;
    repeat (10) tick();
    check("t3_no_strobes", strobe_cnt - s0, 0);
    check("t3_req_held", m_req, 1);
    m_gnt = 1'b1;
    wait_done(base_d, "t3");
    tick();
    check("t3_done_once", done_cnt - base_d, 1);
    check_quiet("t3");

    // restart with a new source at byte 100
    base_d = done_cnt;
    base_w = wr_cnt;
    start_xfer(8'hC1);
    wait_wr(base_w + 100, "t4");
    start_xfer(8'hD0);
    wait_done(base_d, "t4");
    repeat (20) tick();
    check("t4_done_once", done_cnt - base_d, 1);
    check_quiet("t4");

    // reset aborts a transfer at byte 30
    base_d = done_cnt;
    base_w = wr_cnt;
    start_xfer(8'h45);
    wait_wr(base_w + 30, "t5");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rd_q.delete();
    wr_q.delete();
    check("t5_req", m_req, 0);
    check("t5_strobes", {m_rd, m_wr}, 0);
    check("t5_busy", busy, 0);
    s0 = strobe_cnt;
    repeat (600) tick();
    check("t5_no_strobes", strobe_cnt - s0, 0);
    check("t5_no_done", done_cnt - base_d, 0);
    cpu_read(DMA_ADDR, 1'b1, 8'h00, "t5_src");

    // reset wins over a simultaneous start write
    reset = 1'b1; s_addr = DMA_ADDR; s_wdata = 8'h33; s_we = 1'b1;
    tick();
    reset = 1'b0; s_we = 1'b0; s_addr = '0; s_wdata = '0;
    tick();
    check("rst_we_busy", busy, 0);
    cpu_read(DMA_ADDR, 1'b1, 8'h00, "rst_we_src");

`ifdef OAM_DMA_STATUS_EN
    // sticky status register
    base_d = done_cnt;
    start_xfer(8'h22);
    repeat (5) tick();
    cpu_read(DMA_ADDR + 16'd1, 1'b1, 8'h01, "t6_mid");
    wait_done(base_d, "t6");
    tick();
    cpu_read(DMA_ADDR + 16'd1, 1'b1, 8'h80, "t6_after");
    cpu_read(DMA_ADDR + 16'd1, 1'b1, 8'h00, "t6_cleared");
    check_quiet("t6");
`endif

    // start write landing in the DONE cycle
    base_d = done_cnt;
    base_w = wr_cnt;
    start_xfer(8'h7E);
    wait_wr(base_w + XFER_LEN, "t7");
    start_xfer(8'h3B);
    check("t7_first_done", done_cnt - base_d, 1);
    check("t7_restart_busy", busy, 1);
    wait_done(base_d + 1, "t7");
    tick();
    check("t7_done_twice", done_cnt - base_d, 2);
    check_quiet("t7");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
